// File: rtl/timer_reset_sync.sv
// -----------------------------------------------------------------------------
// timer_reset_sync
//   Two-flop reset synchroniser for an active-low reset. Assertion passes
//   straight through asynchronously; deassertion is re-timed to clk so that
//   downstream flops all leave reset on the same clock edge.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous active-low reset in (0 = asserted)
//   reset_sync : active-low reset out, async assert / sync deassert
// -----------------------------------------------------------------------------
module timer_reset_sync (
    input  logic clk,
    input  logic reset,
    output logic reset_sync
);

    logic [1:0] sync_q;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    // The second stage is the only one allowed to fan out; the first stage
    // may still be settling from metastability.
    assign reset_sync = sync_q[1];

endmodule

// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer
//   On-delay (hold) timer. hit_target asserts once `in` has been sampled high
//   on `target` consecutive rising clock edges, and drops in the same cycle
//   `in` falls. Used to qualify power-supply-active signals before they are
//   declared OK.
//
// Parameters
//   WIDTH      : width of the cycle counter and of the target port
//
// Ports
//   clk        : system clock, all state updates on its rising edge
//   reset      : asynchronous active-low reset (0 = asserted)
//   target     : required number of consecutive high cycles (unsigned)
//   in         : level being qualified, active high
//   hit_target : high while `in` is high and has been high >= target cycles
// -----------------------------------------------------------------------------
module timer #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target,
    input  logic             in,
    output logic             hit_target
);

    logic             reset_sync;
    logic [WIDTH-1:0] count;
    logic             at_target;

    timer_reset_sync u_reset_sync (
        .clk        (clk),
        .reset      (reset),
        .reset_sync (reset_sync)
    );

    // Counter clears the instant reset asserts (the synchroniser passes the
    // assertion through asynchronously) and resumes only after the
    // synchronised release. It saturates at target rather than wrapping, so
    // an all-ones target simply parks the count at 2^WIDTH-1.
    //
    // NOTE: only the counter register is reset here; there is no memory or
    // datapath storage that would need to be excluded from the reset tree.
    always_ff @(posedge clk or negedge reset_sync) begin
        if (!reset_sync) begin
            count <= '0;
        end else if (!in) begin
            count <= '0;
        end else if (count < target) begin
            count <= count + WIDTH'(1);
        end
    end

    // Compare against the live target so a target change takes effect at
    // once, in either direction.
    assign at_target  = (count >= target);

    // Gated by the raw reset level and the raw input so the output falls
    // with no added latency.
    assign hit_target = reset & in & at_target;

endmodule

// File: tb/tb_timer.sv
// -----------------------------------------------------------------------------
// tb_timer
//   Self-checking bench for timer. Three instances share clk, reset and in:
//   a WIDTH=4 instance for the detailed scenarios and WIDTH=21 / WIDTH=22
//   instances standing in for the card-size timers. A behavioural model
//   tracks, per instance, how long `in` has been held (capped at the target)
//   and predicts hit_target from the rule "reset & in & held >= target".
//   The synchronised reset release makes the third rising edge after
//   release the first one that counts.
// -----------------------------------------------------------------------------
module tb_timer;

    logic        clk;
    logic        reset;
    logic        in_lvl;
    logic [3:0]  tgt4;
    logic [20:0] tgt21;
    logic [21:0] tgt22;
    logic        hit4;
    logic        hit21;
    logic        hit22;

    int n_vec;
    int n_err;

    // Model state
    int   held [3];     // consecutive counted high edges, capped at target
    int   rel_edges;    // rising edges seen since reset was released
    logic obs  [3];     // sampled DUT outputs for the current step
    logic expv [3];     // model prediction for the current step
    int   cyc;

    timer #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .target     (tgt4),
        .in         (in_lvl),
        .hit_target (hit4)
    );

    timer #(.WIDTH(21)) dut21 (
        .clk        (clk),
        .reset      (reset),
        .target     (tgt21),
        .in         (in_lvl),
        .hit_target (hit21)
    );

    timer #(.WIDTH(22)) dut22 (
        .clk        (clk),
        .reset      (reset),
        .target     (tgt22),
        .in         (in_lvl),
        .hit_target (hit22)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cur_tgt(input int k);
        case (k)
            0:       return int'(tgt4);
            1:       return int'(tgt21);
            default: return int'(tgt22);
        endcase
    endfunction

    function automatic logic model_hit(input int k);
        return reset && in_lvl && (held[k] >= cur_tgt(k));
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) held[k] = 0;
        rel_edges = 0;
    endfunction

    // Rising-edge model: counting only once two edges have passed since the
    // reset release (synchroniser latency).
    function automatic void model_edge();
        if (reset) begin
            if (rel_edges >= 2) begin
                for (int k = 0; k < 3; k++) begin
                    if (!in_lvl)                 held[k] = 0;
                    else if (held[k] < cur_tgt(k)) held[k] = held[k] + 1;
                end
            end
            if (rel_edges < 2) rel_edges = rel_edges + 1;
        end
    endfunction

    function automatic void sample();
        obs[0] = hit4;
        obs[1] = hit21;
        obs[2] = hit22;
        for (int k = 0; k < 3; k++) expv[k] = model_hit(k);
    endfunction

    // One clock cycle: drive `in` on the falling edge, sample outputs just
    // after, then advance the model on the rising edge. Returns 1 ns after
    // the rising edge so callers can change inputs away from any edge.
    task automatic step(input logic v);
        @(negedge clk);
        in_lvl = v;
        #1;
        sample();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic assert_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        sample();
    endtask

    task automatic release_reset();
        #2;
        reset = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        in_lvl = 1'b1;
        tgt4   = 4'd5;
        tgt21  = 21'd3;
        tgt22  = 22'd0;          // target 0 must still be gated by reset
        #1 reset = 1'b0;
        model_reset();
        #1;
        sample();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (obs[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_async[%0d]: hit_target=%b required 0", k, obs[k]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs[k] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_held[%0d] step %0d: hit_target=%b required 0", k, i, obs[k]);
                end
            end
        end
        release_reset();
        for (int j = 1; j <= 12; j++) begin
            step(1'b1);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs[k] !== expv[k]) begin
                    n_err++;
                    $display("FAIL reset_release[%0d] step %0d: hit_target=%b required %b", k, j, obs[k], expv[k]);
                end
            end
            // At most j-1 edges have passed, so 5 counted edges are impossible
            // before step 6; after 11 edges (9 counted) the hit must be up.
            if (j <= 5 || j == 12) begin
                n_vec++;
                if (hit4 !== (j == 12)) begin
                    n_err++;
                    $display("FAIL reset_release_bound step %0d: hit_target=%b required %b", j, hit4, (j == 12));
                end
            end
        end
    endtask

    task automatic test_nominal();
        tgt4 = 4'd5;
        step(1'b0);
        step(1'b0);
        for (int j = 1; j <= 30; j++) begin
            step(1'b1);
            n_vec++;
            if (obs[0] !== (j - 1 >= 5)) begin
                n_err++;
                $display("FAIL nominal edge %0d: hit_target=%b required %b", j - 1, obs[0], (j - 1 >= 5));
            end
            for (int k = 1; k < 3; k++) begin
                n_vec++;
                if (obs[k] !== expv[k]) begin
                    n_err++;
                    $display("FAIL nominal_model[%0d] step %0d: hit_target=%b required %b", k, j, obs[k], expv[k]);
                end
            end
        end
    endtask

    task automatic test_restart();
        tgt4 = 4'd5;
        step(1'b0);
        for (int j = 0; j < 3; j++) step(1'b1);
        step(1'b0);
        n_vec++;
        if (obs[0] !== 1'b0) begin
            n_err++;
            $display("FAIL restart_glitch: hit_target=%b required 0", obs[0]);
        end
        for (int j = 1; j <= 8; j++) begin
            step(1'b1);
            n_vec++;
            if (obs[0] !== (j - 1 >= 5)) begin
                n_err++;
                $display("FAIL restart edge %0d: hit_target=%b required %b", j - 1, obs[0], (j - 1 >= 5));
            end
        end
        step(1'b0);   // hit must drop in the same cycle in falls
        n_vec++;
        if (obs[0] !== 1'b0) begin
            n_err++;
            $display("FAIL restart_drop: hit_target=%b required 0", obs[0]);
        end
    endtask

    task automatic test_boundaries();
        logic v;
        tgt4 = 4'd0;
        for (int j = 0; j < 20; j++) begin
            v = 1'($urandom_range(0, 1));
            step(v);
            n_vec++;
            if (obs[0] !== v) begin
                n_err++;
                $display("FAIL target0 step %0d: hit_target=%b required %b", j, obs[0], v);
            end
        end
        tgt4 = 4'd15;
        step(1'b0);
        for (int j = 1; j <= 40; j++) begin
            step(1'b1);
            n_vec++;
            if (obs[0] !== (j - 1 >= 15)) begin
                n_err++;
                $display("FAIL target15 edge %0d: hit_target=%b required %b", j - 1, obs[0], (j - 1 >= 15));
            end
        end
    endtask

    task automatic test_dynamic_target();
        tgt4 = 4'd10;
        step(1'b0);
        for (int j = 0; j < 7; j++) step(1'b1);   // held = 7
        tgt4 = 4'd6;
        step(1'b1);
        n_vec++;
        if (obs[0] !== 1'b1) begin
            n_err++;
            $display("FAIL dyn_lower: hit_target=%b required 1", obs[0]);
        end
        tgt4 = 4'd10;
        for (int j = 1; j <= 4; j++) begin
            step(1'b1);
            n_vec++;
            if (obs[0] !== (j == 4)) begin
                n_err++;
                $display("FAIL dyn_raise step %0d: hit_target=%b required %b", j, obs[0], (j == 4));
            end
        end
    endtask

    task automatic test_mid_reset();
        tgt4  = 4'd10;
        tgt22 = 22'd0;
        step(1'b0);
        for (int j = 0; j < 6; j++) step(1'b1);
        assert_reset();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (obs[k] !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_async[%0d]: hit_target=%b required 0", k, obs[k]);
            end
        end
        step(1'b1);
        step(1'b1);
        release_reset();
        for (int j = 1; j <= 15; j++) begin
            step(1'b1);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs[k] !== expv[k]) begin
                    n_err++;
                    $display("FAIL mid_reset_model[%0d] step %0d: hit_target=%b required %b", k, j, obs[k], expv[k]);
                end
            end
            if (j <= 10 || j == 15) begin
                n_vec++;
                if (obs[0] !== (j == 15)) begin
                    n_err++;
                    $display("FAIL mid_reset_restart step %0d: hit_target=%b required %b", j, obs[0], (j == 15));
                end
            end
        end
    endtask

    task automatic test_card_sizes();
        int t21;
        int t22;
        t21   = int'($urandom_range(1200, 1600));
        t22   = int'($urandom_range(2600, 3100));
        tgt21 = 21'(t21);
        tgt22 = 22'(t22);
        tgt4  = 4'd3;
        step(1'b0);
        for (int j = 1; j <= t22 + 3; j++) begin
            step(1'b1);
            if (j == t21 || j == t21 + 1 || j == t22 || j == t22 + 1 || j == t22 + 3) begin
                n_vec += 2;
                if (obs[1] !== (j - 1 >= t21)) begin
                    n_err++;
                    $display("FAIL card21 edge %0d target %0d: hit_target=%b required %b", j - 1, t21, obs[1], (j - 1 >= t21));
                end
                if (obs[2] !== (j - 1 >= t22)) begin
                    n_err++;
                    $display("FAIL card22 edge %0d target %0d: hit_target=%b required %b", j - 1, t22, obs[2], (j - 1 >= t22));
                end
            end
        end
    endtask

    task automatic test_random();
        logic v;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) tgt4  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) tgt21 = 21'($urandom_range(0, 20));
            if ($urandom_range(0, 39) == 0) tgt22 = 22'($urandom_range(0, 20));
            if ($urandom_range(0, 149) == 0) begin
                assert_reset();
                for (int k = 0; k < 3; k++) begin
                    n_vec++;
                    if (obs[k] !== 1'b0) begin
                        n_err++;
                        $display("FAIL random_reset[%0d] iter %0d: hit_target=%b required 0", k, i, obs[k]);
                    end
                end
                step(1'($urandom_range(0, 1)));
                release_reset();
            end
            v = ($urandom_range(0, 99) < 88);
            step(v);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs[k] !== expv[k]) begin
                    n_err++;
                    $display("FAIL random[%0d] iter %0d: hit_target=%b required %b (held %0d target %0d)", k, i, obs[k], expv[k], held[k], cur_tgt(k));
                end
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        cyc    = 0;
        reset  = 1'b1;
        in_lvl = 1'b0;
        tgt4   = '0;
        tgt21  = '0;
        tgt22  = '0;
        model_reset();

        test_reset();
        test_nominal();
        test_restart();
        test_boundaries();
        test_dynamic_target();
        test_mid_reset();
        test_card_sizes();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
